mux_sel_arbiter: RTL and testbench
==================================

// Module: mux_sel_arbiter
// PURPOSE
//   Upstream control stage for the 2:1 mux. Two sources (A, B) request the
//   mux; the block arbitrates round-robin with a bounded hold time, drives
//   sel to the mux, and returns per-source grants. It also emits a registered
//   copy of the selected data with a valid flag for the downstream consumer.
// PARAMETERS
//   W         8   data width of dat_a, dat_b and out_data
//   MAX_HOLD  4   max consecutive grant cycles while the other side waits (>=1)
// PORTS
//   clk       in   1  single clock, all state on posedge
//   rst_n     in   1  reset, synchronous, active-low
//   req_a     in   1  source A request, held until done
//   req_b     in   1  source B request
//   dat_a     in   W  source A data, valid while req_a & gnt_a
//   dat_b     in   W  source B data, valid while req_b & gnt_b
//   sel       out  1  mux select: 0=A, 1=B
//   gnt_a     out  1  A owns the mux (state==GNT_A)
//   gnt_b     out  1  B owns the mux (state==GNT_B)
//   out_valid out  1  out_data holds a transferred word
//   out_data  out  W  registered selected data
// BEHAVIOUR
//   - Reset (rst_n low at posedge): state=IDLE, sel=0, gnt_a=gnt_b=0,
//     out_valid=0, out_data=0, hold_cnt=0, last_sel=1 (A wins first tie).
//     Reset mid-grant drops the grant on that edge; no partial transfer.
//   - FSM states: IDLE, GNT_A, GNT_B. Next state comes from current-cycle
//     reqs. Grants decode registered state, so the first grant is 1 cycle
//     after req.
//   - IDLE: both req -> grant the side != last_sel; one req -> that side;
//     none -> stay. sel holds last value in IDLE.
//   - GNT_A: !req_a & req_b -> GNT_B; !req_a & !req_b -> IDLE;
//     req_a & req_b & hold_cnt==MAX_HOLD-1 -> GNT_B (preempt); else stay.
//     GNT_B: same rules with A and B swapped.
//   - hold_cnt clears on every state change and increments each cycle in a
//     grant state, saturating at MAX_HOLD-1. It is ignored when the other
//     side is idle, so a lone requester holds indefinitely.
//   - last_sel updates to the granted side on entry to GNT_A/GNT_B.
//   - sel=0 in GNT_A, sel=1 in GNT_B; updated on the same edge as the grants.
//   - Datapath (1-cycle latency):
//     out_valid <= (gnt_a & req_a) | (gnt_b & req_b);
//     out_data  <= sel ? dat_b : dat_a.
//     out_data holds its value when out_valid=0.
//   - Grants are never both high. A handover (A->B) gives no idle cycle and
//     no cycle with both grants high.
//   - Width: hold_cnt is $clog2(MAX_HOLD+1) bits. With MAX_HOLD=1, each
//     cycle alternates when both request.
// CONFIGURATION
//   FIXED_PRIO_EN defined: A has strict priority.
//     - IDLE ties go to A.
//     - GNT_B -> GNT_A on the next edge whenever req_a=1.
//     - GNT_A never preempts on hold_cnt.
//     - last_sel is unused. The B hold limit applies only when A requests,
//       which already forces a switch.
//   FIXED_PRIO_EN undefined: round-robin with MAX_HOLD as above (default).
// TESTING
//   1 Reset: rst_n=0 for 2 clks with reqs high -> all outputs 0, sel=0;
//     first post-reset tie grants A.
//   2 Lone A: req_a=1 for 10 clks, dat_a=8'h5A -> gnt_a from cycle 1 through
//     10, never preempted; out_valid=1 from cycle 2 with out_data=8'h5A.
//   3 Contention, MAX_HOLD=4: req_a=req_b=1 from reset -> gnt_a for 4 clks,
//     gnt_b 4, gnt_a 4...; sel toggles with each grant; no overlap or gap.
//   4 Early release: in GNT_A, drop req_a with req_b=1 -> gnt_b on next edge,
//     hold_cnt=0; out_data switches to dat_b 1 clk later.
//   5 Reset mid-op: rst_n=0 during GNT_B, hold_cnt=2 -> next edge IDLE,
//     out_valid=0, last_sel=1; re-release with both req -> A granted.
//   6 FIXED_PRIO_EN: in GNT_B, raise req_a -> gnt_a next edge; both held for
//     20 clks -> gnt_b stays 0.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// mux_sel_arbiter : two-source arbiter driving a 2:1 mux select, with
//                   registered selected-data output. Build option: FIXED_PRIO_EN
// Rev 1.0
// ============================================================================
module mux_sel_arbiter #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] dat_a,
  input  logic [W-1:0] dat_b,
  output logic         sel,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           sel_q, gnt_a_q, gnt_b_q, out_valid_q;
  logic [W-1:0]   out_data_q;
  logic           w_xfer;

`ifndef FIXED_PRIO_EN
  localparam int            HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           last_sel_q;
`endif

  assign w_xfer = (gnt_a_q & req_a) | (gnt_b_q & req_b);

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef FIXED_PRIO_EN
      ST_IDLE: begin
        if (req_a)      state_d = ST_GNT_A;
        else if (req_b) state_d = ST_GNT_B;
      end
      ST_GNT_A: begin
        if (!req_a) state_d = req_b ? ST_GNT_B : ST_IDLE;
      end
      ST_GNT_B: begin
        if (req_a)       state_d = ST_GNT_A;
        else if (!req_b) state_d = ST_IDLE;
      end
`else
      ST_IDLE: begin
        if (req_a && req_b) state_d = last_sel_q ? ST_GNT_A : ST_GNT_B;
        else if (req_a)     state_d = ST_GNT_A;
        else if (req_b)     state_d = ST_GNT_B;
      end
      ST_GNT_A: begin
        if (!req_a)                               state_d = req_b ? ST_GNT_B : ST_IDLE;
        else if (req_b && hold_cnt_q == HOLD_LIM) state_d = ST_GNT_B;
      end
      ST_GNT_B: begin
        if (!req_b)                               state_d = req_a ? ST_GNT_A : ST_IDLE;
        else if (req_a && hold_cnt_q == HOLD_LIM) state_d = ST_GNT_A;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef FIXED_PRIO_EN
  // Counter saturates so a lone requester can hold forever yet yields at once
  // when the other side shows up late.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q)
      hold_cnt_d = '0;
    else if (state_q != ST_IDLE && hold_cnt_q != HOLD_LIM)
      hold_cnt_d = hold_cnt_q + HW'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifndef FIXED_PRIO_EN
      hold_cnt_q  <= '0;
      last_sel_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      gnt_a_q     <= (state_d == ST_GNT_A);
      gnt_b_q     <= (state_d == ST_GNT_B);
      out_valid_q <= w_xfer;
      if (w_xfer)
        out_data_q <= sel_q ? dat_b : dat_a;
      if (state_d == ST_GNT_A)
        sel_q <= 1'b0;
      else if (state_d == ST_GNT_B)
        sel_q <= 1'b1;
`ifndef FIXED_PRIO_EN
      hold_cnt_q <= hold_cnt_d;
      if (state_d != state_q && state_d == ST_GNT_A)
        last_sel_q <= 1'b0;
      else if (state_d != state_q && state_d == ST_GNT_B)
        last_sel_q <= 1'b1;
`endif
    end
  end

  assign sel       = sel_q;
  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// tb_mux_sel_arbiter : directed stimulus checked every cycle against an
// ownership/run-length model, plus literal expectations for key scenarios.
module tb_mux_sel_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_a = 1'b0, req_b = 1'b0;
  logic [W-1:0] dat_a = '0, dat_b = '0;
  logic         sel, gnt_a, gnt_b, out_valid;
  logic [W-1:0] out_data;

  int n_vec = 0;
  int n_bad = 0;
  bit run_chk = 1'b0;

  // Model: owner 0=none,1=A,2=B; run = cycles current owner has held the mux.
  int           m_own = 0, m_last = 2, m_run = 0;
  bit           m_sel = 1'b0, m_val = 1'b0;
  logic [W-1:0] m_dat = '0;

  mux_sel_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .dat_a(dat_a), .dat_b(dat_b), .sel(sel), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int next_owner(input int own, input bit ra, input bit rb,
                                    input int last, input int run);
    int nxt = own;
`ifdef FIXED_PRIO_EN
    if (own == 0)      nxt = ra ? 1 : (rb ? 2 : 0);
    else if (own == 1) nxt = ra ? 1 : (rb ? 2 : 0);
    else               nxt = ra ? 1 : (rb ? 2 : 0);
`else
    bit mine, other;
    if (own == 0) begin
      if (ra && rb) nxt = (last == 1) ? 2 : 1;
      else          nxt = ra ? 1 : (rb ? 2 : 0);
    end else begin
      mine  = (own == 1) ? ra : rb;
      other = (own == 1) ? rb : ra;
      if (!mine)                       nxt = other ? 3 - own : 0;
      else if (other && run >= MAX_HOLD) nxt = 3 - own;
    end
`endif
    return nxt;
  endfunction

  always @(posedge clk) begin
    int nxt;
    if (!rst_n) begin
      m_own = 0; m_sel = 1'b0; m_val = 1'b0; m_dat = '0; m_last = 2; m_run = 0;
    end else begin
      m_val = (m_own == 1 && req_a) || (m_own == 2 && req_b);
      if (m_val) m_dat = m_sel ? dat_b : dat_a;
      nxt = next_owner(m_own, req_a, req_b, m_last, m_run);
      if (nxt != m_own) m_run = (nxt == 0) ? 0 : 1;
      else if (nxt != 0) m_run++;
      if (nxt != 0) begin
        m_sel = (nxt == 2);
        if (nxt != m_own) m_last = nxt;
      end
      m_own = nxt;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("gnt_a", {31'd0, gnt_a}, {31'd0, m_own == 1});
      chk("gnt_b", {31'd0, gnt_b}, {31'd0, m_own == 2});
      chk("sel", {31'd0, sel}, {31'd0, m_sel});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_val});
      chk("out_data", {24'd0, out_data}, {24'd0, m_dat});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct { bit ra; bit rb; } pat_t;
  pat_t pats[$];

  initial begin
    // Reset with both requests high
    req_a = 1'b1; req_b = 1'b1;
    tick(); run_chk = 1'b1;
    tick();
    chk("rst_gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("rst_gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("rst_sel", {31'd0, sel}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);

    // Contention from reset: 4-cycle alternation
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      dat_a = 8'hA0 + 8'(i); dat_b = 8'hB0 + 8'(i);
      tick();
`ifdef FIXED_PRIO_EN
      chk("cont_gnt_a", {31'd0, gnt_a}, 32'd1);
`else
      chk("cont_gnt_a", {31'd0, gnt_a}, (((i - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_gnt_b", {31'd0, gnt_b}, (((i - 1) / 4) % 2 == 1) ? 32'd1 : 32'd0);
`endif
    end

    // Lone A for 10 cycles
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
    req_a = 1'b1; dat_a = 8'h5A;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("lone_gnt_a", {31'd0, gnt_a}, 32'd1);
      if (i >= 2) begin
        chk("lone_valid", {31'd0, out_valid}, 32'd1);
        chk("lone_data", {24'd0, out_data}, 32'h5A);
      end
    end

    // Early release A -> B
    req_a = 1'b0; req_b = 1'b1; dat_b = 8'hC3;
    tick();
    chk("rel_gnt_b", {31'd0, gnt_b}, 32'd1);
    chk("rel_gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("rel_sel", {31'd0, sel}, 32'd1);
    tick();
    chk("rel_valid", {31'd0, out_valid}, 32'd1);
    chk("rel_data", {24'd0, out_data}, 32'hC3);

    // Reset in GNT_B with hold count 2, then tie goes to A
    tick();
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
    tick();
    chk("mid_gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_tie_a", {31'd0, gnt_a}, 32'd1);

    // Mixed request table, model-checked
    pats = '{'{1,0}, '{1,1}, '{0,1}, '{1,1}, '{1,1}, '{1,1}, '{1,1}, '{1,1},
             '{0,0}, '{1,1}, '{0,1}, '{0,0}, '{1,1}, '{1,0}, '{0,1}, '{0,0}};
    foreach (pats[k]) begin
      req_a = pats[k].ra; req_b = pats[k].rb;
      dat_a = 8'(k * 3 + 1); dat_b = 8'(k * 5 + 2);
      tick();
    end

`ifdef FIXED_PRIO_EN
    req_a = 1'b0; req_b = 1'b1;
    tick(); tick();
    req_a = 1'b1;
    tick();
    chk("fp_gnt_a", {31'd0, gnt_a}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("fp_gnt_b", {31'd0, gnt_b}, 32'd0);
    end
`endif

    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
    run_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
